// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Contents: seg_t ({g,f,e,d,c,b,a}), SEG_OFF, HEX_SEG decode table (0-F),
//   and apply_pol() for pin polarity.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  // Active-high segment pattern with every segment dark.
  localparam seg_t SEG_OFF = 7'h00;

  // Active-high hex glyphs, index = nibble value.
  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Map an active-high pattern onto the pin polarity.
  function automatic seg_t apply_pol(seg_t s, bit act_low);
    return act_low ? ~s : s;
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
// Ports: nibble (4-bit value in), seg (active-high {g,f,e,d,c,b,a} out).
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous,
// tear-free value update through a valid/ready load port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable                1 = scan, 0 = dark with counters held at 0
//   load_valid/load_ready load handshake (ready = pending slot empty)
//   load_data/load_blank  nibble k and blank bit k belong to digit k
//   seg, an               registered segment / digit-enable pins
//   frame_done            pulse in the last cycle of each frame
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned PRESCALE    = 50000,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_data,
  input  logic [N_DIGITS-1:0]   load_blank,
  output seg_t                  seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int unsigned PRES_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * N_DIGITS;

  localparam logic [PRES_W-1:0]   PRES_LAST = PRES_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam seg_t                SEG_DARK  = apply_pol(SEG_OFF, SEG_ACT_LOW);
  localparam logic [N_DIGITS-1:0] AN_DARK   = AN_ACT_LOW ? {N_DIGITS{1'b1}} : '0;

  logic [PRES_W-1:0]   pres;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   disp_data;
  logic [N_DIGITS-1:0] disp_blank;
  logic [DATA_W-1:0]   pend_data;
  logic [N_DIGITS-1:0] pend_blank;
  logic                pend_full;

  logic                pres_wrap;
  logic                idx_wrap;
  logic                accept;
  logic                commit;
  logic                lit;
  logic                blank_sel;
  logic [N_DIGITS-1:0] sel_hot;
  logic [3:0]          nibble;
  seg_t                dec_seg;
  seg_t                seg_d;
  logic [N_DIGITS-1:0] an_d;

  // Single decoder shared by all digits; the scanned nibble is muxed in.
  hex_to_seven_seg u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  assign load_ready = ~pend_full;
  assign frame_done = enable & pres_wrap & idx_wrap;

  // Scan decode and handshake qualifiers.
  always_comb begin
    pres_wrap = (pres == PRES_LAST);
    idx_wrap  = (idx == IDX_LAST);
    accept    = load_valid & ~pend_full;
    // A dark display cannot tear, so disabling commits immediately.
    commit    = pend_full & (frame_done | ~enable);
    // pres == 0 is the anti-ghosting dead slot.
    lit       = enable & (pres != '0);
    sel_hot   = N_DIGITS'(1) << idx;
    nibble    = 4'(disp_data >> {idx, 2'b00});
    blank_sel = |(disp_blank & sel_hot);
    seg_d     = apply_pol((lit && !blank_sel) ? dec_seg : SEG_OFF, SEG_ACT_LOW);
    an_d      = lit ? sel_hot : '0;
    if (AN_ACT_LOW) an_d = ~an_d;
  end

  // Counters, load/commit registers and output pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres       <= '0;
      idx        <= '0;
      disp_data  <= '0;
      disp_blank <= '0;
      pend_data  <= '0;
      pend_blank <= '0;
      pend_full  <= 1'b0;
      seg        <= SEG_DARK;
      an         <= AN_DARK;
    end else begin
      if (!enable) begin
        pres <= '0;
        idx  <= '0;
      end else if (pres_wrap) begin
        pres <= '0;
        idx  <= idx_wrap ? '0 : idx + IDX_W'(1);
      end else begin
        pres <= pres + PRES_W'(1);
      end

      if (commit) begin
        disp_data  <= pend_data;
        disp_blank <= pend_blank;
      end
      if (accept) begin
        pend_data  <= load_data;
        pend_blank <= load_blank;
      end
      // accept needs an empty slot and commit a full one: never both.
      if (commit)      pend_full <= 1'b0;
      else if (accept) pend_full <= 1'b1;

      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed, table-driven bench for seven_seg_scan_driver.
// dut: N_DIGITS=4, PRESCALE=4, active-low pins. dut2: N_DIGITS=1, PRESCALE=2,
// active-high segments, used for the full decode sweep.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  logic        enable2;
  logic        load_valid2;
  logic        load_ready2;
  logic [3:0]  load_data2;
  logic [0:0]  load_blank2;
  logic [6:0]  seg2;
  logic [0:0]  an2;
  logic        frame_done2;

  seven_seg_scan_driver #(
    .N_DIGITS(4), .PRESCALE(4), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_blank(load_blank),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  seven_seg_scan_driver #(
    .N_DIGITS(1), .PRESCALE(2), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2),
    .load_valid(load_valid2), .load_ready(load_ready2),
    .load_data(load_data2), .load_blank(load_blank2),
    .seg(seg2), .an(an2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per counter state k = idx*4 + pres; an/seg show state k-1.
  typedef struct {
    logic [3:0] an;
    int         digit;   // -1 = dead slot (all segments dark)
    logic       fd;
  } scan_vec_t;

  // Display value with its inverted glyphs packed {d3,d2,d1,d0}.
  typedef struct {
    logic [15:0] value;
    logic [27:0] segs;
  } val_vec_t;

  localparam int V_ZERO = 0;
  localparam int V1234  = 1;
  localparam int VABCD  = 2;
  localparam int V5678  = 3;
  localparam int V9ABC  = 4;

  scan_vec_t  scan_tab [16];
  val_vec_t   vals [5];
  logic [6:0] dec_exp [16];

  int checks;
  int failures;
  int k;        // counter state of dut after the last edge
  int disp_v;   // value index the bench expects on display
  int pend_v;   // value index the bench expects pending, -1 = empty

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of dut with an optional load offer (lv = value index, -1 = none).
  task automatic step(input int lv);
    bit          had_pend;
    bit          acc;
    bit          fd_edge;
    int          prev_disp;
    logic [27:0] s;
    logic [6:0]  seg_e;
    if (lv >= 0) begin
      load_valid = 1'b1;
      load_data  = vals[lv].value;
    end else begin
      load_valid = 1'b0;
      load_data  = 16'hFFFF;
    end
    had_pend  = (pend_v >= 0);
    acc       = (lv >= 0) && !had_pend;
    fd_edge   = (k == 15);
    prev_disp = disp_v;
    @(posedge clk);
    @(negedge clk);
    if (fd_edge && had_pend) begin
      disp_v = pend_v;
      pend_v = -1;
    end
    if (acc) pend_v = lv;
    k = (k + 1) % 16;
    s = vals[prev_disp].segs;
    if (scan_tab[k].digit < 0) seg_e = 7'h7F;
    else                       seg_e = s[scan_tab[k].digit*7 +: 7];
    chk($sformatf("scan_an k=%0d", k), 32'(an), 32'(scan_tab[k].an));
    chk($sformatf("scan_seg k=%0d", k), 32'(seg), 32'(seg_e));
    chk($sformatf("scan_fd k=%0d", k), 32'(frame_done), 32'(scan_tab[k].fd));
    chk($sformatf("scan_ready k=%0d", k), 32'(load_ready), 32'(pend_v < 0));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    scan_tab[0]  = '{an: 4'h7, digit:  3, fd: 1'b0};
    scan_tab[1]  = '{an: 4'hF, digit: -1, fd: 1'b0};
    scan_tab[2]  = '{an: 4'hE, digit:  0, fd: 1'b0};
    scan_tab[3]  = '{an: 4'hE, digit:  0, fd: 1'b0};
    scan_tab[4]  = '{an: 4'hE, digit:  0, fd: 1'b0};
    scan_tab[5]  = '{an: 4'hF, digit: -1, fd: 1'b0};
    scan_tab[6]  = '{an: 4'hD, digit:  1, fd: 1'b0};
    scan_tab[7]  = '{an: 4'hD, digit:  1, fd: 1'b0};
    scan_tab[8]  = '{an: 4'hD, digit:  1, fd: 1'b0};
    scan_tab[9]  = '{an: 4'hF, digit: -1, fd: 1'b0};
    scan_tab[10] = '{an: 4'hB, digit:  2, fd: 1'b0};
    scan_tab[11] = '{an: 4'hB, digit:  2, fd: 1'b0};
    scan_tab[12] = '{an: 4'hB, digit:  2, fd: 1'b0};
    scan_tab[13] = '{an: 4'hF, digit: -1, fd: 1'b0};
    scan_tab[14] = '{an: 4'h7, digit:  3, fd: 1'b0};
    scan_tab[15] = '{an: 4'h7, digit:  3, fd: 1'b1};

    vals[V_ZERO] = '{value: 16'h0000, segs: {7'h40, 7'h40, 7'h40, 7'h40}};
    vals[V1234]  = '{value: 16'h1234, segs: {7'h79, 7'h24, 7'h30, 7'h19}};
    vals[VABCD]  = '{value: 16'hABCD, segs: {7'h08, 7'h03, 7'h46, 7'h21}};
    vals[V5678]  = '{value: 16'h5678, segs: {7'h12, 7'h02, 7'h78, 7'h00}};
    vals[V9ABC]  = '{value: 16'h9ABC, segs: {7'h10, 7'h08, 7'h03, 7'h46}};

    dec_exp = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    rst_n       = 1'b0;
    enable      = 1'b0;
    load_valid  = 1'b0;
    load_data   = 16'h0000;
    load_blank  = 4'h0;
    enable2     = 1'b0;
    load_valid2 = 1'b0;
    load_data2  = 4'h0;
    load_blank2 = 1'b0;

    // Reset state.
    repeat (10) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_seg2", 32'(seg2), 32'h00);
    chk("rst_an2", 32'(an2), 32'h1);
    rst_n = 1'b1;

    // Load while disabled: accept, then commit on the next disabled cycle.
    load_valid = 1'b1;
    load_data  = 16'h1234;
    @(posedge clk); @(negedge clk);
    chk("dis_accept_ready", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    load_data  = 16'hFFFF;
    @(posedge clk); @(negedge clk);
    chk("dis_commit_ready", 32'(load_ready), 32'h1);
    chk("dis_dark_an", 32'(an), 32'hF);
    chk("dis_dark_seg", 32'(seg), 32'h7F);

    // Scan 1234 across two full frames and into a third.
    disp_v = V1234;
    pend_v = -1;
    k      = 0;
    enable = 1'b1;
    repeat (36) step(-1);

    // Tear-free: ABCD offered mid-frame, shown only after the frame end.
    step(VABCD);
    repeat (13) step(-1);

    // Back-pressure: second load held until the first commits.
    step(V5678);
    repeat (14) step(V9ABC);
    repeat (31) step(-1);

    // Disable at idx=2 with a load pending: dark next cycle, commit now.
    step(VABCD);
    repeat (9) step(-1);
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("disable_an", 32'(an), 32'hF);
    chk("disable_seg", 32'(seg), 32'h7F);
    chk("disable_fd", 32'(frame_done), 32'h0);
    chk("disable_commit_ready", 32'(load_ready), 32'h1);
    disp_v = VABCD;
    pend_v = -1;
    k      = 0;
    enable = 1'b1;
    repeat (18) step(-1);

    // Reset pulse at idx=1 with a load pending: dark at once, pending lost.
    repeat (2) step(-1);
    step(V1234);
    rst_n = 1'b0;
    #1;
    chk("rstpulse_an", 32'(an), 32'hF);
    chk("rstpulse_seg", 32'(seg), 32'h7F);
    chk("rstpulse_ready", 32'(load_ready), 32'h1);
    chk("rstpulse_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    disp_v = V_ZERO;
    pend_v = -1;
    k      = 0;
    repeat (20) step(-1);
    enable = 1'b0;

    // Decode sweep on the single-digit, active-high instance; entry 16 = blank.
    for (int n = 0; n < 17; n++) begin
      load_valid2 = 1'b1;
      load_data2  = (n < 16) ? 4'(n) : 4'h8;
      load_blank2 = 1'((n == 16) ? 1 : 0);
      @(posedge clk); @(negedge clk);
      load_valid2 = 1'b0;
      @(posedge clk); @(negedge clk);
      enable2 = 1'b1;
      @(posedge clk); @(negedge clk);
      chk($sformatf("dec_fd n=%0d", n), 32'(frame_done2), 32'h1);
      @(posedge clk); @(negedge clk);
      chk($sformatf("dec_seg n=%0d", n), 32'(seg2), (n < 16) ? 32'(dec_exp[n]) : 32'h00);
      chk($sformatf("dec_an n=%0d", n), 32'(an2), 32'h0);
      enable2 = 1'b0;
      @(posedge clk); @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
